inst_fetch_axi: RTL and testbench
=================================

Name: inst_fetch_axi

Overview:
Instruction-side responder to the program counter.
- Accepts one fetch request (virtual PC) at a time and applies the fixed-segment address map.
- Issues a single-beat AXI4 read and returns the 32-bit instruction to the IF stage.
- Drives a stall that holds the PC until the word is delivered.
- Handles redirect flushes (branch/exception) for transactions already in flight.

Parameters:
AXI_ID, 4'd0, constant arid; rid is not checked.
ADDR_MAP, 1, 1 = apply kseg0/kseg1 mapping; 0 = pass the address through unchanged.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  PC has a fetch request
req_addr  in  32  virtual fetch address (PC)
flush  in  1  redirect pending; discard current/in-flight fetch
stall_if  out  1  1 = hold PC (drive pc_en low)
inst_valid  out  1  one-cycle pulse: instruction delivered
inst_data  out  32  fetched word
inst_addr  out  32  virtual address of the delivered word
inst_adel  out  1  with inst_valid: misaligned fetch, no bus access made
inst_berr  out  1  with inst_valid: AXI error response
arid  out  4  = AXI_ID
araddr  out  32  physical address
arlen  out  8  constant 0
arsize  out  3  constant 3'b010
arburst  out  2  constant 2'b01
arvalid  out  1  read address valid
arready  in  1  read address ready
rid  in  4  ignored
rdata  in  32  read data
rresp  in  2  read response
rlast  in  1  last beat
rvalid  in  1  read data valid
rready  out  1  read data ready

Behaviour:
- Reset (reset high at a clk edge):
  - State goes to IDLE.
  - arvalid, rready, inst_valid, inst_adel, inst_berr, discard flag all 0.
  - araddr, inst_addr, inst_data all 0.
  - Reset aborts any transaction in progress, including mid-AR or mid-R.
- Address map (ADDR_MAP=1):
  - addr[31:30]==2'b10 -> {3'b0, addr[28:0]}.
  - Otherwise unchanged.
- States: IDLE, AR, R, DONE.
- IDLE:
  - Condition to accept: req_valid & ~flush.
  - On accept, latch inst_addr <= req_addr and araddr <= mapped address.
  - If req_addr[1:0] != 0: go to DONE with inst_adel=1 and inst_data=0. No AXI traffic.
  - Otherwise go to AR.
  - flush in IDLE has priority: the request is ignored.
- AR:
  - arvalid=1, held stable until arready.
  - On arready, go to R.
- R:
  - rready=1.
  - On rvalid & rlast: latch inst_data <= rdata and inst_berr <= (rresp[1]==1), then go to DONE.
  - If inst_berr, inst_data is forced to 0.
- DONE:
  - inst_valid=1 for exactly one cycle (unless discarded), then IDLE.
  - inst_adel and inst_berr are meaningful only while inst_valid=1; they are 0 otherwise.
- Flush rules:
  - AXI handshakes are never abandoned.
  - flush while in AR or R sets the discard flag. The transaction completes normally.
  - In DONE with discard=1 or flush=1: inst_valid stays 0, discard clears, go to IDLE.
  - A new request is accepted no earlier than the cycle after returning to IDLE.
- stall_if = req_valid & ~(state==DONE & ~discard & ~flush). The PC advances only in the delivery cycle.
- Latency: request seen in IDLE at cycle 0.
  - arvalid at cycle 1.
  - With arready at cycle 1 and rvalid at cycle 2, inst_valid is at cycle 3.
  - Each wait cycle on arready or rvalid adds one cycle.
- One outstanding transaction only. rvalid outside state R is ignored (rready=0).

Test Plan:
- Basic fetch: reset, req_addr=0xBFC00000, arready and rvalid immediate, rdata=0x3C08BFC0, rresp=0 -> araddr=0x1FC00000 at cycle 1; inst_valid at cycle 3 with inst_data=0x3C08BFC0 and inst_addr=0xBFC00000; stall_if low only at cycle 3.
- Map/passthrough: req_addr=0x80001000 -> araddr=0x00001000; req_addr=0x00400000 -> araddr=0x00400000; req_addr=0xC0000000 -> araddr=0xC0000000.
- Misaligned: req_addr=0xBFC00002 -> no arvalid; inst_valid with inst_adel=1, inst_data=0 at cycle 1.
- Backpressure plus error: arready low 3 cycles, rvalid 2 cycles later with rresp=2'b10 -> arvalid held 4 cycles with stable araddr; inst_valid with inst_berr=1 and inst_data=0.
- Flush in flight: flush pulse while in R, rdata=0x12345678 -> R handshake completes, no inst_valid; the next request for 0xBFC00380 is delivered normally.
- Reset mid-transaction: reset while arvalid=1 -> next cycle arvalid=0, state IDLE, all outputs 0; a following fetch completes normally.

Source files
------------

// File: rtl/inst_fetch_axi.sv
// Instruction fetch responder: maps the PC, issues one single-beat AXI4 read at a time,
// returns the word to the IF stage and absorbs redirect flushes without abandoning handshakes.
module inst_fetch_axi #(
  parameter logic [3:0] AXI_ID   = 4'd0,
  parameter bit         ADDR_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        stall_if,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_addr,
  output logic        inst_adel,
  output logic        inst_berr,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        discard_q, discard_d;
  logic        adel_q, adel_d;
  logic        berr_q, berr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic        unused_rid;

  // kseg0/kseg1 both fold onto the low 512 MB of physical space.
  function automatic logic [31:0] map_addr(input logic [31:0] a);
    if (ADDR_MAP && (a[31:30] == 2'b10)) return {3'b000, a[28:0]};
    return a;
  endfunction

  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    adel_d      = adel_q;
    berr_d      = berr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    araddr_d    = araddr_q;
    inst_addr_d = inst_addr_q;
    inst_data_d = inst_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          inst_addr_d = req_addr;
          araddr_d    = map_addr(req_addr);
          discard_d   = 1'b0;
          berr_d      = 1'b0;
          if (req_addr[1:0] != 2'b00) begin
            adel_d      = 1'b1;
            inst_data_d = 32'h0;
            state_d     = S_DONE;
          end else begin
            adel_d    = 1'b0;
            arvalid_d = 1'b1;
            state_d   = S_AR;
          end
        end
      end
      S_AR: begin
        if (flush) discard_d = 1'b1;
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (flush) discard_d = 1'b1;
        if (rvalid && rlast) begin
          rready_d    = 1'b0;
          berr_d      = rresp[1];
          inst_data_d = rresp[1] ? 32'h0 : rdata;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        discard_d = 1'b0;
        adel_d    = 1'b0;
        berr_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      discard_q   <= 1'b0;
      adel_q      <= 1'b0;
      berr_q      <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      araddr_q    <= 32'h0;
      inst_addr_q <= 32'h0;
      inst_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      adel_q      <= adel_d;
      berr_q      <= berr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      araddr_q    <= araddr_d;
      inst_addr_q <= inst_addr_d;
      inst_data_q <= inst_data_d;
    end
  end

  // A flush arriving in the delivery cycle itself still suppresses the word.
  assign inst_valid = (state_q == S_DONE) && !discard_q && !flush;
  assign inst_adel  = inst_valid && adel_q;
  assign inst_berr  = inst_valid && berr_q;
  assign stall_if   = req_valid && !inst_valid;
  assign inst_data  = inst_data_q;
  assign inst_addr  = inst_addr_q;

  assign arid    = AXI_ID;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign unused_rid = ^rid;

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Directed bench for inst_fetch_axi: a table of fetch vectors with per-cycle checks,
// plus hand-written flush and mid-transaction reset sequences.
module tb_inst_fetch_axi;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        flush;
  logic        stall_if;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_addr;
  logic        inst_adel;
  logic        inst_berr;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inst_fetch_axi dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
    .stall_if(stall_if), .inst_valid(inst_valid), .inst_data(inst_data), .inst_addr(inst_addr),
    .inst_adel(inst_adel), .inst_berr(inst_berr), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready), .rid(rid),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic [31:0] addr;
    int          ar_wait;
    int          r_wait;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [31:0] exp_araddr;
    logic        exp_adel;
    logic        exp_berr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];
  vec_t v_after;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle 0 begins at the next rising edge; inputs change 1 time unit after each edge
  // and outputs are sampled 1 time unit later.
  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = v.addr;
    #1;
    chk("c0_stall", stall_if, 1'b1);
    chk("c0_arvalid", arvalid, 1'b0);
    @(posedge clk); #1;
    if (v.exp_adel) begin
      #1;
      chk("adel_arvalid", arvalid, 1'b0);
      chk("adel_valid", inst_valid, 1'b1);
      chk("adel_flag", inst_adel, 1'b1);
      chk("adel_data", inst_data, 32'h0);
      chk("adel_addr", inst_addr, v.addr);
      chk("adel_stall", stall_if, 1'b0);
    end else begin
      for (int w = 0; w <= v.ar_wait; w++) begin
        arready = (w == v.ar_wait);
        #1;
        chk("ar_arvalid", arvalid, 1'b1);
        chk("ar_araddr", araddr, v.exp_araddr);
        chk("ar_valid", inst_valid, 1'b0);
        chk("ar_stall", stall_if, 1'b1);
        @(posedge clk); #1;
        arready = 1'b0;
      end
      for (int w = 0; w <= v.r_wait; w++) begin
        rvalid = (w == v.r_wait);
        rlast  = (w == v.r_wait);
        rdata  = (w == v.r_wait) ? v.rdata : 32'h0;
        rresp  = v.rresp;
        #1;
        chk("r_rready", rready, 1'b1);
        chk("r_arvalid", arvalid, 1'b0);
        chk("r_valid", inst_valid, 1'b0);
        @(posedge clk); #1;
        rvalid = 1'b0;
        rlast  = 1'b0;
      end
      #1;
      chk("done_valid", inst_valid, 1'b1);
      chk("done_data", inst_data, v.exp_data);
      chk("done_addr", inst_addr, v.addr);
      chk("done_berr", inst_berr, v.exp_berr);
      chk("done_adel", inst_adel, 1'b0);
      chk("done_stall", stall_if, 1'b0);
      chk("done_rready", rready, 1'b0);
    end
    req_valid = 1'b0;
    @(posedge clk); #1; #1;
    chk("post_valid", inst_valid, 1'b0);
    chk("post_berr", inst_berr, 1'b0);
    chk("post_adel", inst_adel, 1'b0);
    chk("post_arvalid", arvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; flush = 1'b0;
    arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

    //            addr          arw rw rdata         rresp  araddr        adel  berr  data
    vecs[0] = '{32'hBFC00000, 0, 0, 32'h3C08BFC0, 2'b00, 32'h1FC00000, 1'b0, 1'b0, 32'h3C08BFC0};
    vecs[1] = '{32'h80001000, 0, 0, 32'hDEADBEEF, 2'b00, 32'h00001000, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{32'h00400000, 0, 0, 32'h24020001, 2'b00, 32'h00400000, 1'b0, 1'b0, 32'h24020001};
    vecs[3] = '{32'hC0000000, 1, 0, 32'h0000000C, 2'b00, 32'hC0000000, 1'b0, 1'b0, 32'h0000000C};
    vecs[4] = '{32'hBFC00002, 0, 0, 32'h0,        2'b00, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[5] = '{32'hBFC00100, 3, 2, 32'hAAAA5555, 2'b10, 32'h1FC00100, 1'b0, 1'b1, 32'h0};
    vecs[6] = '{32'hA0000004, 0, 1, 32'h01234567, 2'b01, 32'h00000004, 1'b0, 1'b0, 32'h01234567};

    repeat (2) @(posedge clk);
    #1; reset = 1'b0; #1;
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_inst_addr", inst_addr, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_stall", stall_if, 1'b0);
    chk("const_arid", arid, 4'h0);
    chk("const_arlen", arlen, 8'h0);
    chk("const_arsize", arsize, 3'b010);
    chk("const_arburst", arburst, 2'b01);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Flush while idle: request ignored.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'hBFC00000; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("fidle_arvalid", arvalid, 1'b0);
    chk("fidle_valid", inst_valid, 1'b0);

    // Flush while in R: handshake completes, nothing delivered.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'hBFC00000;
    @(posedge clk); #1;
    arready = 1'b1; #1;
    chk("fr_arvalid", arvalid, 1'b1);
    @(posedge clk); #1;
    arready = 1'b0; flush = 1'b1; #1;
    chk("fr_rready", rready, 1'b1);
    chk("fr_stall", stall_if, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h12345678; rresp = 2'b00; #1;
    chk("fr_rready_held", rready, 1'b1);
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0; #1;
    chk("fr_no_valid", inst_valid, 1'b0);
    chk("fr_stall_done", stall_if, 1'b1);
    chk("fr_rready_drop", rready, 1'b0);
    req_valid = 1'b0;
    @(posedge clk); #1; #1;
    chk("fr_idle_valid", inst_valid, 1'b0);
    v_after = '{32'hBFC00380, 0, 0, 32'h40806000, 2'b00, 32'h1FC00380, 1'b0, 1'b0, 32'h40806000};
    run_vec(v_after);

    // Flush in the delivery cycle suppresses inst_valid.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h80000040;
    @(posedge clk); #1;
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h11112222;
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0; flush = 1'b1; #1;
    chk("fd_valid", inst_valid, 1'b0);
    chk("fd_stall", stall_if, 1'b1);
    flush = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1; #1;
    chk("fd_post_valid", inst_valid, 1'b0);
    chk("fd_post_arvalid", arvalid, 1'b0);

    // Reset while arvalid is high aborts the transaction.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h80002000;
    @(posedge clk); #1; #1;
    chk("rm_arvalid_pre", arvalid, 1'b1);
    req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    chk("rm_arvalid", arvalid, 1'b0);
    chk("rm_rready", rready, 1'b0);
    chk("rm_valid", inst_valid, 1'b0);
    chk("rm_araddr", araddr, 32'h0);
    chk("rm_inst_addr", inst_addr, 32'h0);
    chk("rm_inst_data", inst_data, 32'h0);
    @(posedge clk); #1; #1;
    chk("rm_idle_arvalid", arvalid, 1'b0);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
